// File: rtl/mio_responder_pkg.sv
// Shared constants, state/region types and the address decoder for mio_responder.
package mio_pkg;

   localparam logic [31:0] MIO_GPIO_ADDR = 32'hE000_0000;
   localparam logic [31:0] MIO_CNT_ADDR  = 32'hF000_0000;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} mio_state_t;
   typedef enum logic [1:0] {RAM, GPIO, CNT, NONE} mio_region_t;

   // Word-granular decode; byte offset bits are ignored for the peripherals.
   function automatic mio_region_t mio_decode(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic        cnt_en);
      mio_region_t r;
      r = NONE;
      if (addr < ram_bytes)
         r = RAM;
      else if (addr[31:2] == MIO_GPIO_ADDR[31:2])
         r = GPIO;
      else if (cnt_en && (addr[31:2] == MIO_CNT_ADDR[31:2]))
         r = CNT;
      return r;
   endfunction

endpackage

// File: rtl/mio_responder_if.sv
// CPU memory-port request/response signals; master = CPU side, slave = responder side.
interface mio_responder_if;
   logic        CPU_MIO;
   logic        mem_w;
   logic [31:0] Addr_out;
   logic [31:0] Data_out;
   logic [31:0] Data_in;
   logic        MIO_ready;

   modport master (output CPU_MIO, mem_w, Addr_out, Data_out,
                   input  Data_in, MIO_ready);
   modport slave  (input  CPU_MIO, mem_w, Addr_out, Data_out,
                   output Data_in, MIO_ready);
endinterface

// File: rtl/mio_responder_word_ram.sv
// Single-port RAM_WORDS x 32 synchronous RAM; one-cycle registered read.
// No backpressure: a write is committed on the edge where we is high.
module mio_word_ram #(
   parameter  int RAM_WORDS = 1024,
   localparam int AW        = $clog2(RAM_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [RAM_WORDS];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mio_responder.sv
// Memory/IO responder: RAM, GPIO and (with MIO_COUNTER_EN) a counter; MIO_ready in cycle WAIT_CYCLES+2.
// One transaction in flight; CPU_MIO is ignored until the FSM returns to IDLE.
module mio_responder
   import mio_pkg::*;
#(
   parameter int RAM_WORDS   = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   mio_responder_if.slave       bus,
   input  logic [15:0]          sw_in,
   output logic [15:0]          led_out,
   output logic                 bus_err
);

   localparam int          AW        = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
`ifdef MIO_COUNTER_EN
   localparam logic        CNT_EN    = 1'b1;
`else
   localparam logic        CNT_EN    = 1'b0;
`endif

   mio_state_t  state, state_nxt;
   logic [3:0]  wait_q, wait_nxt;
   logic [31:0] addr_q, wdata_q, rdata_q, ram_rdata, cnt_rd;
   logic        wr_q, commit, ram_we;
   logic [AW-1:0] ram_addr;
   mio_region_t region;

   assign region = mio_decode(addr_q, RAM_BYTES, CNT_EN);
   assign commit = (state == WAIT) && (wait_q == 4'd0);
   assign ram_we = commit && wr_q && (region == RAM);
   // Address the RAM straight from the bus while idle so a zero-wait read has data ready on its commit edge.
   assign ram_addr = (state == IDLE) ? bus.Addr_out[AW+1:2] : addr_q[AW+1:2];

   assign bus.Data_in   = rdata_q;
   assign bus.MIO_ready = (state == DONE);

   mio_word_ram #(.RAM_WORDS(RAM_WORDS)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_q;
      unique case (state)
         IDLE: if (bus.CPU_MIO) begin
            state_nxt = WAIT;
            wait_nxt  = WAIT_INIT;
         end
         WAIT: if (wait_q != 4'd0) wait_nxt = wait_q - 4'd1;
               else                state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         wait_q  <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
         led_out <= '0;
         bus_err <= 1'b0;
      end else begin
         state  <= state_nxt;
         wait_q <= wait_nxt;
         if (state == IDLE && bus.CPU_MIO) begin
            addr_q  <= bus.Addr_out;
            wdata_q <= bus.Data_out;
            wr_q    <= bus.mem_w;
         end
         if (commit) begin
            unique case (region)
               RAM:  if (!wr_q) rdata_q <= ram_rdata;
               GPIO: if (wr_q) led_out <= wdata_q[15:0];
                     else      rdata_q <= {16'b0, sw_in};
               CNT:  if (!wr_q) rdata_q <= cnt_rd;
               default: begin
                  bus_err <= 1'b1;
                  if (!wr_q) rdata_q <= '0;
               end
            endcase
         end
      end
   end

`ifdef MIO_COUNTER_EN
   logic [31:0] cnt_q;
   assign cnt_rd = cnt_q;

   // A write on the same edge as an increment takes priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= '0;
      else if (commit && wr_q && region == CNT)
         cnt_q <= wdata_q;
      else
         cnt_q <= cnt_q + 32'd1;
   end
`else
   assign cnt_rd = '0;
`endif

endmodule

// File: tb/tb_mio_responder.sv
// Self-checking bench for mio_responder: two instances (WAIT_CYCLES 1 and 3) against a behavioural model.
module tb_mio_responder;
   import mio_pkg::*;

   logic        clk = 1'b0;
   logic        rst1 = 1'b0, rst3 = 1'b0;
   logic [15:0] sw1 = '0, sw3 = '0, led1, led3;
   logic        err1, err3;
   int          cyc = 0;
   int          total = 0, bad = 0;

   mio_responder_if bus1();
   mio_responder_if bus3();

   mio_responder #(.RAM_WORDS(1024), .WAIT_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst1), .bus(bus1), .sw_in(sw1), .led_out(led1), .bus_err(err1));
   mio_responder #(.RAM_WORDS(1024), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst3), .bus(bus3), .sw_in(sw3), .led_out(led3), .bus_err(err3));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic v, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      if (sel) begin
         bus3.CPU_MIO = v; bus3.mem_w = w; bus3.Addr_out = a; bus3.Data_out = d;
      end else begin
         bus1.CPU_MIO = v; bus1.mem_w = w; bus1.Addr_out = a; bus1.Data_out = d;
      end
   endtask

   function automatic logic rdy(input bit sel);
      return sel ? bus3.MIO_ready : bus1.MIO_ready;
   endfunction

   function automatic logic [31:0] din(input bit sel);
      return sel ? bus3.Data_in : bus1.Data_in;
   endfunction

   // One request; scrambles the bus after acceptance. lat = cycle index of MIO_ready (-1 on timeout).
   task automatic xact(input bit sel, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output int lat, output int acc);
      @(negedge clk);
      drive(sel, 1'b1, wr, a, d);
      @(posedge clk); #1;
      acc = cyc;
      drive(sel, 1'b0, 1'($urandom), $urandom, $urandom);
      lat = -1;
      rd  = 'x;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (rdy(sel)) begin
            lat = n;
            rd  = din(sel);
            break;
         end
      end
      @(negedge clk);
      check("ready_one_cycle", 32'(rdy(sel)), 32'd0);
   endtask

   // Reference model for dut1.
   logic [31:0] ram_m [int];
   logic [31:0] exp_din;
   logic [15:0] exp_led;
   logic        exp_err;

   function automatic int region_of(input logic [31:0] a);
      if (a < 32'd4096)                       return 0;
      if ((a & ~32'd3) == 32'hE000_0000)      return 1;
`ifdef MIO_COUNTER_EN
      if ((a & ~32'd3) == 32'hF000_0000)      return 2;
`endif
      return 3;
   endfunction

   task automatic model_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [15:0] sw);
      int r;
      r = region_of(a);
      if (wr) begin
         if (r == 0) ram_m[int'(a >> 2)] = d;
         else if (r == 1) exp_led = d[15:0];
         else if (r == 3) exp_err = 1'b1;
      end else begin
         if (r == 0) exp_din = ram_m[int'(a >> 2)];
         else if (r == 1) exp_din = {16'h0, sw};
         else if (r == 3) begin exp_din = 32'h0; exp_err = 1'b1; end
      end
   endtask

   initial begin
      logic [31:0] rd, a, d, unm3;
      int lat, acc, acc_w, n1, n2, kind;
      bit wr;

      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      exp_din = '0; exp_led = '0; exp_err = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_din",   bus1.Data_in,       32'h0);
      check("rst_ready", 32'(bus1.MIO_ready), 32'h0);
      check("rst_led",   32'(led1),          32'h0);
      check("rst_err",   32'(err1),          32'h0);
      rst1 = 1'b1; rst3 = 1'b1;

      // RAM write then read
      xact(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, lat, acc);
      model_op(1'b1, 32'h10, 32'hDEAD_BEEF, sw1);
      check("ram_wr_lat", 32'(lat), 32'd3);
      xact(1'b0, 1'b0, 32'h10, 32'h0, rd, lat, acc);
      model_op(1'b0, 32'h10, 32'h0, sw1);
      check("ram_rd_lat",  32'(lat), 32'd3);
      check("ram_rd_data", rd, 32'hDEAD_BEEF);

      // GPIO
      xact(1'b0, 1'b1, 32'hE000_0000, 32'h0001_A5A5, rd, lat, acc);
      model_op(1'b1, 32'hE000_0000, 32'h0001_A5A5, sw1);
      check("gpio_led", 32'(led1), 32'h0000_A5A5);
      check("gpio_wr_keeps_din", rd, 32'hDEAD_BEEF);
      sw1 = 16'h1234;
      xact(1'b0, 1'b0, 32'hE000_0000, 32'h0, rd, lat, acc);
      model_op(1'b0, 32'hE000_0000, 32'h0, sw1);
      check("gpio_rd", rd, 32'h0000_1234);

`ifdef MIO_COUNTER_EN
      // Counter: write near wrap, read back; count elapsed edges between commits
      xact(1'b0, 1'b1, 32'hF000_0000, 32'hFFFF_FFFE, rd, lat, acc_w);
      check("cnt_load_exact", dut1.cnt_q, 32'hFFFF_FFFF);
      xact(1'b0, 1'b0, 32'hF000_0000, 32'h0, rd, lat, acc);
      check("cnt_wrap", rd, 32'hFFFF_FFFE + 32'(acc - acc_w - 1));
      check("cnt_small", 32'(rd < 32'd16), 32'd1);
      xact(1'b0, 1'b1, 32'hF000_0003, 32'h1234_5678, rd, lat, acc_w);
      check("cnt_write_wins", dut1.cnt_q, 32'h1234_5679);
      xact(1'b0, 1'b0, 32'hF000_0000, 32'h0, rd, lat, acc);
      check("cnt_rd", rd, 32'h1234_5678 + 32'(acc - acc_w - 1));
      exp_din = rd;
      unm3 = 32'h8000_0004;
`else
      unm3 = 32'hF000_0000;
`endif
      check("err_clear_before", 32'(err1), 32'h0);

      // Unmapped
      xact(1'b0, 1'b0, 32'h8000_0000, 32'h0, rd, lat, acc);
      model_op(1'b0, 32'h8000_0000, 32'h0, sw1);
      check("unm_rd", rd, 32'h0);
      check("unm_err", 32'(err1), 32'h1);
      xact(1'b0, 1'b0, 32'h10, 32'h0, rd, lat, acc);
      model_op(1'b0, 32'h10, 32'h0, sw1);
      check("unm_then_ram", rd, 32'hDEAD_BEEF);
      check("err_sticky", 32'(err1), 32'h1);

      // Randomized traffic against the model
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         xact(1'b0, 1'b1, 32'(i * 4), d, rd, lat, acc);
         model_op(1'b1, 32'(i * 4), d, sw1);
      end
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 2);
         wr   = 1'($urandom);
         d    = $urandom;
         sw1  = 16'($urandom);
         if (kind == 0)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
         else if (kind == 1) a = 32'hE000_0000 + 32'($urandom_range(0, 3));
         else                a = 32'($urandom_range(4096, 32'h7FFF_FFFF));
         xact(1'b0, wr, a, d, rd, lat, acc);
         model_op(wr, a, d, sw1);
         check("rnd_lat",  32'(lat), 32'd3);
         check("rnd_din",  rd, exp_din);
         check("rnd_led",  32'(led1), 32'(exp_led));
         check("rnd_err",  32'(err1), 32'(exp_err));
      end

      // Back-to-back: CPU_MIO held through DONE and the following IDLE cycle
      a = 32'h14;
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, a, 32'h0);
      n1 = -1; n2 = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (bus1.MIO_ready) begin
            if (n1 < 0) n1 = n;
            else begin n2 = n; break; end
            check("b2b_first_data", bus1.Data_in, ram_m[5]);
         end
         if (n1 >= 0 && n == n1 + 1) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         end
      end
      check("b2b_first_lat", 32'(n1), 32'd3);
      check("b2b_spacing",   32'(n2 - n1), 32'd4);
      check("b2b_second_data", bus1.Data_in, ram_m[5]);
      @(negedge clk);
      check("b2b_no_third", 32'(bus1.MIO_ready), 32'h0);

      // Reset mid-access on the WAIT_CYCLES=3 instance
      xact(1'b1, 1'b1, 32'h20, 32'hAAAA_0001, rd, lat, acc);
      check("w3_wr_lat", 32'(lat), 32'd5);
      xact(1'b1, 1'b1, 32'hE000_0000, 32'h0000_00FF, rd, lat, acc);
      check("w3_led", 32'(led3), 32'h0000_00FF);
      xact(1'b1, 1'b0, unm3, 32'h0, rd, lat, acc);
      check("w3_unm_rd",  rd, 32'h0);
      check("w3_unm_err", 32'(err3), 32'h1);
      xact(1'b1, 1'b0, 32'h20, 32'h0, rd, lat, acc);
      check("w3_rd_prior", rd, 32'hAAAA_0001);
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, 32'h20, 32'h55);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      rst3 = 1'b0;
      #1;
      check("mid_rst_din",   bus3.Data_in, 32'h0);
      check("mid_rst_ready", 32'(bus3.MIO_ready), 32'h0);
      check("mid_rst_led",   32'(led3), 32'h0);
      check("mid_rst_err",   32'(err3), 32'h0);
      check("mid_rst_state", 32'(dut3.state), 32'(IDLE));
      repeat (6) begin
         @(negedge clk);
         check("mid_rst_no_ready", 32'(bus3.MIO_ready), 32'h0);
      end
      rst3 = 1'b1;
      xact(1'b1, 1'b0, 32'h20, 32'h0, rd, lat, acc);
      check("post_rst_lat",  32'(lat), 32'd5);
      check("post_rst_data", rd, 32'hAAAA_0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
